hec_delineate: RTL and testbench
================================

// Module: hec_delineate
// PURPOSE
//  Receive-side counterpart of the HEC generator. It takes an unframed ATM byte stream and
//  finds cell boundaries by checking the HEC (ITU I.432 HUNT/PRESYNC/SYNC). Only cells with
//  a valid header are forwarded, with a start-of-cell marker. Sits between the line byte
//  deserialiser and the cell consumer. Header checks use one instance of hec_cal
//  (CRC-8 poly 0x07, coset 0x55).
// PARAMETERS
//  CELL_BYTES  53  bytes per cell, header (4) + HEC (1) included; fixed header length 5
//  DELTA       6   consecutive correct HECs after the hunt hit needed for PRESYNC->SYNC
//  ALPHA       7   consecutive incorrect HECs in SYNC needed for SYNC->HUNT
//  DROP_IDLE   1   1: discard idle cells (header 32'h0000_0001) even when the HEC is correct
// PORTS
//  clk         in   1  single clock, rising edge
//  rst_n       in   1  asynchronous, active-low reset
//  rx_valid    in   1  rx_data is valid this cycle; gaps are allowed, and only valid cycles count
//  rx_data     in   8  line byte, first-transmitted byte of the header = hdr[31:24]
//  cell_valid  out  1  cell_data is valid (registered)
//  cell_data   out  8  forwarded cell byte
//  cell_soc    out  1  with cell_valid: first header byte of a cell
//  sync_state  out  2  00 HUNT, 01 PRESYNC, 10 SYNC (11 never driven)
//  hec_err     out  1  one-cycle pulse: a header check failed in PRESYNC or SYNC
// BEHAVIOUR
//  - Reset: all outputs 0; state HUNT; shift register, fill, pos, good_cnt, bad_cnt, emit_cnt = 0.
//  - Pipeline: 5-byte shift register sr[4:0], shifted on each rx_valid. sr[0] = newest byte.
//    On each shift, sr[4] leaves the register as the "outgoing" byte.
//  - Check: hdr = {sr[4],sr[3],sr[2],sr[1]} and ok = (hec_cal(hdr) == sr[0]). The check is
//    evaluated combinationally after the shift. Its effects are registered at that edge.
//  - Check timing:
//    HUNT: on every valid byte once fill == 5 (fill saturates at 5). The first 4 bytes after
//    reset or HUNT entry are never checked.
//    PRESYNC and SYNC: only when pos == CELL_BYTES-1 on a valid byte.
//    pos counts valid bytes since the last check. It resets to 0 at each check, and wraps
//    0..CELL_BYTES-1.
//  - FSM:
//    HUNT: ok -> PRESYNC, good_cnt = 0, pos = 0.
//    PRESYNC, check ok: good_cnt+1. When it reaches DELTA -> SYNC with bad_cnt = 0.
//    PRESYNC, check fail: -> HUNT, fill = 0, hec_err pulse.
//    SYNC, check ok: bad_cnt = 0.
//    SYNC, check fail: bad_cnt+1 and hec_err pulse. When bad_cnt reaches ALPHA -> HUNT, fill = 0.
//  - Forwarding: at each check, pass = ok && (next state == SYNC) && !(DROP_IDLE && hdr == 32'h1).
//    emit_cnt is loaded with CELL_BYTES when pass=1, else 0.
//    On each following valid byte with emit_cnt > 0: cell_data <= outgoing byte, cell_valid <= 1,
//    cell_soc <= (emit_cnt == CELL_BYTES), emit_cnt-1.
//    Latency: header byte 1 appears 1 cycle after the valid byte following the HEC byte.
//  - Back-to-back cells: the cell's last outgoing byte and the next check occur on the same
//    valid. The emit_cnt decrement to 0 and the reload both happen; the reload wins.
//  - Cell on the PRESYNC->SYNC transition check is forwarded. Cells checked in PRESYNC are never
//    forwarded. In HUNT, emit_cnt is forced to 0.
//  - Without rx_valid: cell_valid, cell_soc, hec_err = 0 next cycle; all state and counters hold.
//  - Reset mid-operation: immediate return to reset values; a partial cell is dropped silently.
//  - Widths: pos and emit_cnt are $clog2(CELL_BYTES+1). good_cnt and bad_cnt are sized for
//    DELTA and ALPHA with no wrap.
// TESTING
//  1 Reset, then 8 cells (hdr 32'h1234_5678, correct HEC, payload 0..47), no gaps.
//    -> PRESYNC after byte 5; SYNC after byte 323 (7th HEC).
//    -> First cell_soc on cycle after valid 324, data 8'h12; cells 7 and 8 forwarded in full;
//       hec_err never set.
//  2 3 garbage bytes 8'hA5 before stream of 1 -> delineation found at byte 8.
//    -> First forwarded soc after valid 327; no cell before it.
//  3 In SYNC, corrupt HEC (xor 8'h01) of 6 consecutive cells.
//    -> 6 hec_err pulses, those cells not forwarded, state stays 10.
//    -> A good cell then resets bad_cnt and is forwarded. Repeat with 7 bad cells -> state 00
//       after the 7th.
//  4 In PRESYNC, one bad HEC at the 3rd check -> hec_err pulse, state 00.
//    -> Re-hunt needs ≥5 bytes before the next hit.
//  5 In SYNC, idle cell (00 00 00 01 + correct HEC) -> dropped with DROP_IDLE=1, forwarded
//    with DROP_IDLE=0.
//  6 Random rx_valid gaps (50%) over stream of 1 -> identical output byte sequence.
//    Then assert rst_n low mid-payload -> all outputs 0, state 00, no spurious soc afterwards.

Source files
------------

// File: rtl/hec_delineate.sv
// ATM cell delineation. The block hunts for a correct HEC byte by byte, confirms the
// cell grid over several aligned headers, then forwards cells with valid headers.
// Each forwarded cell carries a start-of-cell marker. hec_cal holds the header CRC.

// CRC-8 (x^8+x^2+x+1) over a 32-bit header, MSB first, with the 0x55 coset added.
module hec_cal (
    input  logic [31:0] hdr,
    output logic [7:0]  hec
);
    logic [7:0] crc [0:32];

    assign crc[0] = 8'h00;

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_bit
            logic fb;
            assign fb         = crc[gi][7] ^ hdr[31-gi];
            assign crc[gi+1]  = {crc[gi][6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
    endgenerate

    assign hec = crc[32] ^ 8'h55;
endmodule

module hec_delineate #(
    parameter int CELL_BYTES = 53,
    parameter int DELTA      = 6,
    parameter int ALPHA      = 7,
    parameter bit DROP_IDLE  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       cell_valid,
    output logic [7:0] cell_data,
    output logic       cell_soc,
    output logic [1:0] sync_state,
    output logic       hec_err
);
    localparam int PW = $clog2(CELL_BYTES + 1);
    localparam int GW = $clog2(DELTA + 1);
    localparam int BW = $clog2(ALPHA + 1);

    typedef enum logic [1:0] {
        ST_HUNT    = 2'b00,
        ST_PRESYNC = 2'b01,
        ST_SYNC    = 2'b10
    } state_t;

    state_t          state_q, state_d;
    logic [4:0][7:0] sr_q, sr_d;
    logic [2:0]      fill_q, fill_d;
    logic [PW-1:0]   pos_q, pos_d;
    logic [PW-1:0]   emit_cnt_q, emit_cnt_d;
    logic [GW-1:0]   good_cnt_q, good_cnt_d;
    logic [BW-1:0]   bad_cnt_q, bad_cnt_d;
    logic            cell_valid_q, cell_valid_d;
    logic [7:0]      cell_data_q, cell_data_d;
    logic            cell_soc_q, cell_soc_d;
    logic            hec_err_q, hec_err_d;

    // The check looks at the register contents as they will be after this byte shifts in.
    logic [4:0][7:0] sr_shift;
    logic [31:0]     hdr;
    logic [7:0]      hec_calc;
    logic            ok;
    logic            do_check;
    logic            pass;

    assign sr_shift = {sr_q[3:0], rx_data};
    assign hdr      = sr_shift[4:1];
    assign ok       = (hec_calc == sr_shift[0]);

    hec_cal u_hec_cal (
        .hdr (hdr),
        .hec (hec_calc)
    );

    // Next-state logic: shift, check scheduling, hunt/presync/sync FSM and cell forwarding.
    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        fill_d       = fill_q;
        pos_d        = pos_q;
        emit_cnt_d   = emit_cnt_q;
        good_cnt_d   = good_cnt_q;
        bad_cnt_d    = bad_cnt_q;
        cell_valid_d = 1'b0;
        cell_data_d  = cell_data_q;
        cell_soc_d   = 1'b0;
        hec_err_d    = 1'b0;
        do_check     = 1'b0;
        pass         = 1'b0;

        if (rx_valid) begin
            sr_d   = sr_shift;
            fill_d = (fill_q == 3'd5) ? 3'd5 : fill_q + 3'd1;

            // Forward the byte leaving the register while a passed cell is still draining.
            if (state_q != ST_HUNT && emit_cnt_q != '0) begin
                cell_valid_d = 1'b1;
                cell_data_d  = sr_q[4];
                cell_soc_d   = (emit_cnt_q == PW'(CELL_BYTES));
                emit_cnt_d   = emit_cnt_q - 1'b1;
            end

            // Hunting checks every byte once the register is full; otherwise once per cell.
            if (state_q == ST_HUNT) begin
                do_check = (fill_q >= 3'd4);
            end else begin
                do_check = (pos_q == PW'(CELL_BYTES - 1));
            end
            pos_d = do_check ? '0 : pos_q + 1'b1;

            case (state_q)
                ST_HUNT: begin
                    pos_d      = '0;
                    emit_cnt_d = '0;
                    if (do_check && ok) begin
                        state_d    = ST_PRESYNC;
                        good_cnt_d = '0;
                    end
                end
                ST_PRESYNC: begin
                    if (do_check) begin
                        if (ok) begin
                            good_cnt_d = good_cnt_q + 1'b1;
                            if (good_cnt_q + 1'b1 == GW'(DELTA)) begin
                                state_d   = ST_SYNC;
                                bad_cnt_d = '0;
                            end
                        end else begin
                            state_d   = ST_HUNT;
                            fill_d    = 3'd0;
                            hec_err_d = 1'b1;
                        end
                    end
                end
                ST_SYNC: begin
                    if (do_check) begin
                        if (ok) begin
                            bad_cnt_d = '0;
                        end else begin
                            bad_cnt_d = bad_cnt_q + 1'b1;
                            hec_err_d = 1'b1;
                            if (bad_cnt_q + 1'b1 == BW'(ALPHA)) begin
                                state_d = ST_HUNT;
                                fill_d  = 3'd0;
                            end
                        end
                    end
                end
                default: state_d = ST_HUNT;
            endcase

            // A reload at a check overrides the final decrement of the previous cell.
            if (do_check) begin
                pass       = ok && (state_d == ST_SYNC) &&
                             !(DROP_IDLE && hdr == 32'h0000_0001);
                emit_cnt_d = pass ? PW'(CELL_BYTES) : '0;
            end
        end
    end

    // State and output registers; an asynchronous reset drops any partial cell.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_HUNT;
            sr_q         <= '0;
            fill_q       <= '0;
            pos_q        <= '0;
            emit_cnt_q   <= '0;
            good_cnt_q   <= '0;
            bad_cnt_q    <= '0;
            cell_valid_q <= 1'b0;
            cell_data_q  <= '0;
            cell_soc_q   <= 1'b0;
            hec_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            fill_q       <= fill_d;
            pos_q        <= pos_d;
            emit_cnt_q   <= emit_cnt_d;
            good_cnt_q   <= good_cnt_d;
            bad_cnt_q    <= bad_cnt_d;
            cell_valid_q <= cell_valid_d;
            cell_data_q  <= cell_data_d;
            cell_soc_q   <= cell_soc_d;
            hec_err_q    <= hec_err_d;
        end
    end

    assign cell_valid = cell_valid_q;
    assign cell_data  = cell_data_q;
    assign cell_soc   = cell_soc_q;
    assign sync_state = state_q;
    assign hec_err    = hec_err_q;
endmodule

// File: tb/tb_hec_delineate.sv
// Directed bench for hec_delineate: acquisition, garbage prefix, sync loss, presync loss,
// idle-cell filtering (two instances with DROP_IDLE 1 and 0), input gaps and mid-run reset.
module tb_hec_delineate;
    localparam logic [31:0] HDR      = 32'h1234_5678;
    localparam logic [7:0]  HEC_OK   = 8'h49;
    localparam logic [31:0] IDLE_HDR = 32'h0000_0001;
    localparam logic [7:0]  IDLE_HEC = 8'h52;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data  = 8'h00;

    logic       cv0, cs0, he0, cv1, cs1, he1;
    logic [7:0] cd0, cd1;
    logic [1:0] st0, st1;

    hec_delineate #(.CELL_BYTES(53), .DELTA(6), .ALPHA(7), .DROP_IDLE(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .cell_valid(cv0), .cell_data(cd0), .cell_soc(cs0), .sync_state(st0), .hec_err(he0)
    );

    hec_delineate #(.CELL_BYTES(53), .DELTA(6), .ALPHA(7), .DROP_IDLE(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .cell_valid(cv1), .cell_data(cd1), .cell_soc(cs1), .sync_state(st1), .hec_err(he1)
    );

    always #5 clk = ~clk;

    int         pass_cnt = 0;
    int         total_cnt = 0;
    int         vcount, err0, err1, gap_bad;
    logic [7:0] out0[$];
    logic [7:0] out1[$];
    logic [7:0] exp_q[$];
    int         soc0[$];
    int         soc1[$];
    logic [1:0] hist [0:2047];
    logic [1:0] hec_state;
    bit         gaps_on = 1'b0;

    task automatic clear_log();
        vcount = 0; err0 = 0; err1 = 0; gap_bad = 0;
        out0.delete(); out1.delete(); exp_q.delete(); soc0.delete(); soc1.delete();
        for (int i = 0; i < 2048; i++) hist[i] = 2'b11;
    endtask

    // One clock cycle: drive on the falling edge, record outputs 1 time unit after the rise.
    task automatic send(input logic [7:0] b, input logic v);
        @(negedge clk);
        rx_valid = v;
        rx_data  = b;
        @(posedge clk);
        #1;
        if (v) vcount++;
        if (cv0) begin out0.push_back(cd0); if (cs0) soc0.push_back(vcount); end
        if (cv1) begin out1.push_back(cd1); if (cs1) soc1.push_back(vcount); end
        if (he0) err0++;
        if (he1) err1++;
        if (v && vcount < 2048) hist[vcount] = st0;
        if (!v && (cv0 || cs0 || he0)) gap_bad++;
    endtask

    task automatic send_g(input logic [7:0] b);
        if (gaps_on && $urandom_range(0, 1) == 1) send(8'h00, 1'b0);
        send(b, 1'b1);
    endtask

    task automatic send_hdr(input logic [31:0] h, input logic [7:0] e);
        send_g(h[31:24]); send_g(h[23:16]); send_g(h[15:8]); send_g(h[7:0]);
        send_g(e);
        hec_state = st0;
    endtask

    task automatic send_cell(input logic [31:0] h, input logic [7:0] e);
        send_hdr(h, e);
        for (int i = 0; i < 48; i++) send_g(8'(i));
    endtask

    task automatic push_cell(input logic [31:0] h, input logic [7:0] e);
        exp_q.push_back(h[31:24]); exp_q.push_back(h[23:16]);
        exp_q.push_back(h[15:8]);  exp_q.push_back(h[7:0]);
        exp_q.push_back(e);
        for (int i = 0; i < 48; i++) exp_q.push_back(8'(i));
    endtask

    function automatic int first_diff0();
        int n = (out0.size() < exp_q.size()) ? out0.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (out0[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    function automatic int first_soc0();
        return (soc0.size() > 0) ? soc0[0] : -1;
    endfunction

    task automatic apply_reset();
        rx_valid = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_log();
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total_cnt++; if (cv0 !== 1'b0) $display("FAIL reset_cell_valid: got %b want 0", cv0); else pass_cnt++;
        total_cnt++; if (cd0 !== 8'h00) $display("FAIL reset_cell_data: got %h want 00", cd0); else pass_cnt++;
        total_cnt++; if (cs0 !== 1'b0) $display("FAIL reset_cell_soc: got %b want 0", cs0); else pass_cnt++;
        total_cnt++; if (st0 !== 2'b00) $display("FAIL reset_sync_state: got %b want 00", st0); else pass_cnt++;
        total_cnt++; if (he0 !== 1'b0) $display("FAIL reset_hec_err: got %b want 0", he0); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        clear_log();
    endtask

    task automatic test_acquire();
        int d;
        apply_reset();
        for (int c = 0; c < 8; c++) send_cell(HDR, HEC_OK);
        send_hdr(HDR, HEC_OK);
        push_cell(HDR, HEC_OK); push_cell(HDR, HEC_OK);
        d = first_diff0();
        total_cnt++; if (hist[4] !== 2'b00) $display("FAIL acq_state_b4: got %b want 00", hist[4]); else pass_cnt++;
        total_cnt++; if (hist[5] !== 2'b01) $display("FAIL acq_state_b5: got %b want 01", hist[5]); else pass_cnt++;
        total_cnt++; if (hist[322] !== 2'b01) $display("FAIL acq_state_b322: got %b want 01", hist[322]); else pass_cnt++;
        total_cnt++; if (hist[323] !== 2'b10) $display("FAIL acq_state_b323: got %b want 10", hist[323]); else pass_cnt++;
        total_cnt++; if (first_soc0() != 324) $display("FAIL acq_first_soc: got %0d want 324", first_soc0()); else pass_cnt++;
        total_cnt++; if (soc0.size() != 2) $display("FAIL acq_soc_count: got %0d want 2", soc0.size()); else pass_cnt++;
        total_cnt++; if (out0.size() != 106) $display("FAIL acq_byte_count: got %0d want 106", out0.size()); else pass_cnt++;
        total_cnt++; if (d != -1) $display("FAIL acq_bytes: first diff at %0d got %h want %h", d, out0[d], exp_q[d]); else pass_cnt++;
        total_cnt++; if (err0 != 0) $display("FAIL acq_hec_err: got %0d pulses want 0", err0); else pass_cnt++;
    endtask

    task automatic test_garbage();
        int d;
        apply_reset();
        repeat (3) send_g(8'hA5);
        for (int c = 0; c < 8; c++) send_cell(HDR, HEC_OK);
        send_hdr(HDR, HEC_OK);
        push_cell(HDR, HEC_OK); push_cell(HDR, HEC_OK);
        d = first_diff0();
        total_cnt++; if (hist[7] !== 2'b00) $display("FAIL garb_state_b7: got %b want 00", hist[7]); else pass_cnt++;
        total_cnt++; if (hist[8] !== 2'b01) $display("FAIL garb_state_b8: got %b want 01", hist[8]); else pass_cnt++;
        total_cnt++; if (first_soc0() != 327) $display("FAIL garb_first_soc: got %0d want 327", first_soc0()); else pass_cnt++;
        total_cnt++; if (out0.size() != 106) $display("FAIL garb_byte_count: got %0d want 106", out0.size()); else pass_cnt++;
        total_cnt++; if (d != -1) $display("FAIL garb_bytes: first diff at %0d got %h want %h", d, out0[d], exp_q[d]); else pass_cnt++;
    endtask

    task automatic test_sync_errors();
        int d;
        apply_reset();
        for (int c = 0; c < 7; c++) send_cell(HDR, HEC_OK);
        for (int c = 0; c < 6; c++) send_cell(HDR, HEC_OK ^ 8'h01);
        total_cnt++; if (hec_state !== 2'b10) $display("FAIL sync6_state: got %b want 10", hec_state); else pass_cnt++;
        total_cnt++; if (err0 != 6) $display("FAIL sync6_err: got %0d pulses want 6", err0); else pass_cnt++;
        send_cell(HDR, HEC_OK);
        total_cnt++; if (hec_state !== 2'b10) $display("FAIL sync_good_state: got %b want 10", hec_state); else pass_cnt++;
        for (int c = 0; c < 6; c++) send_cell(HDR, HEC_OK ^ 8'h01);
        total_cnt++; if (hec_state !== 2'b10) $display("FAIL sync_rerun6_state: got %b want 10", hec_state); else pass_cnt++;
        send_cell(HDR, HEC_OK ^ 8'h01);
        total_cnt++; if (hec_state !== 2'b00) $display("FAIL sync7_state: got %b want 00", hec_state); else pass_cnt++;
        total_cnt++; if (err0 != 13) $display("FAIL sync_err_total: got %0d pulses want 13", err0); else pass_cnt++;
        push_cell(HDR, HEC_OK); push_cell(HDR, HEC_OK);
        d = first_diff0();
        total_cnt++; if (out0.size() != 106) $display("FAIL sync_byte_count: got %0d want 106", out0.size()); else pass_cnt++;
        total_cnt++; if (d != -1) $display("FAIL sync_bytes: first diff at %0d got %h want %h", d, out0[d], exp_q[d]); else pass_cnt++;
        total_cnt++; if (soc0.size() != 2) $display("FAIL sync_soc_count: got %0d want 2", soc0.size()); else pass_cnt++;
    endtask

    task automatic test_presync_error();
        logic [7:0] trap [9];
        trap = '{8'h00, 8'h00, 8'h01, 8'h52, 8'h00, 8'h00, 8'h00, 8'h01, 8'h52};
        apply_reset();
        for (int c = 0; c < 3; c++) send_cell(HDR, HEC_OK);
        send_hdr(HDR, 8'h00);
        for (int i = 0; i < 9; i++) send_g(trap[i]);
        total_cnt++; if (hist[111] !== 2'b01) $display("FAIL pre_state_chk2: got %b want 01", hist[111]); else pass_cnt++;
        total_cnt++; if (hist[164] !== 2'b00) $display("FAIL pre_state_fail: got %b want 00", hist[164]); else pass_cnt++;
        total_cnt++; if (err0 != 1) $display("FAIL pre_hec_err: got %0d pulses want 1", err0); else pass_cnt++;
        total_cnt++; if (hist[168] !== 2'b00) $display("FAIL pre_early_hit: got %b want 00", hist[168]); else pass_cnt++;
        total_cnt++; if (hist[172] !== 2'b00) $display("FAIL pre_state_b172: got %b want 00", hist[172]); else pass_cnt++;
        total_cnt++; if (hist[173] !== 2'b01) $display("FAIL pre_rehunt_hit: got %b want 01", hist[173]); else pass_cnt++;
        total_cnt++; if (out0.size() != 0) $display("FAIL pre_no_output: got %0d bytes want 0", out0.size()); else pass_cnt++;
    endtask

    task automatic test_idle();
        logic [7:0] g0, g1;
        logic [39:0] idle1;
        apply_reset();
        for (int c = 0; c < 7; c++) send_cell(HDR, HEC_OK);
        send_cell(IDLE_HDR, IDLE_HEC);
        send_cell(HDR, HEC_OK);
        g0    = (out0.size() > 53) ? out0[53] : 8'hxx;
        g1    = (out1.size() > 106) ? out1[106] : 8'hxx;
        idle1 = (out1.size() > 57) ? {out1[53], out1[54], out1[55], out1[56], out1[57]} : 40'hx;
        total_cnt++; if (out0.size() != 101) $display("FAIL idle_drop_count: got %0d want 101", out0.size()); else pass_cnt++;
        total_cnt++; if (soc0.size() != 2) $display("FAIL idle_drop_soc: got %0d want 2", soc0.size()); else pass_cnt++;
        total_cnt++; if (g0 !== 8'h12) $display("FAIL idle_drop_next: got %h want 12", g0); else pass_cnt++;
        total_cnt++; if (out1.size() != 154) $display("FAIL idle_keep_count: got %0d want 154", out1.size()); else pass_cnt++;
        total_cnt++; if (soc1.size() != 3) $display("FAIL idle_keep_soc: got %0d want 3", soc1.size()); else pass_cnt++;
        total_cnt++; if (idle1 !== 40'h00_0000_0152) $display("FAIL idle_keep_hdr: got %h want 0000000152", idle1); else pass_cnt++;
        total_cnt++; if (g1 !== 8'h12) $display("FAIL idle_keep_next: got %h want 12", g1); else pass_cnt++;
        total_cnt++; if (st1 !== 2'b10) $display("FAIL idle_keep_state: got %b want 10", st1); else pass_cnt++;
        total_cnt++; if (err1 != 0) $display("FAIL idle_keep_err: got %0d want 0", err1); else pass_cnt++;
    endtask

    task automatic test_gaps_and_reset();
        int d;
        apply_reset();
        gaps_on = 1'b1;
        for (int c = 0; c < 8; c++) send_cell(HDR, HEC_OK);
        send_hdr(HDR, HEC_OK);
        gaps_on = 1'b0;
        push_cell(HDR, HEC_OK); push_cell(HDR, HEC_OK);
        d = first_diff0();
        total_cnt++; if (hist[5] !== 2'b01) $display("FAIL gap_state_b5: got %b want 01", hist[5]); else pass_cnt++;
        total_cnt++; if (hist[322] !== 2'b01) $display("FAIL gap_state_b322: got %b want 01", hist[322]); else pass_cnt++;
        total_cnt++; if (hist[323] !== 2'b10) $display("FAIL gap_state_b323: got %b want 10", hist[323]); else pass_cnt++;
        total_cnt++; if (first_soc0() != 324) $display("FAIL gap_first_soc: got %0d want 324", first_soc0()); else pass_cnt++;
        total_cnt++; if (out0.size() != 106) $display("FAIL gap_byte_count: got %0d want 106", out0.size()); else pass_cnt++;
        total_cnt++; if (d != -1) $display("FAIL gap_bytes: first diff at %0d got %h want %h", d, out0[d], exp_q[d]); else pass_cnt++;
        total_cnt++; if (gap_bad != 0) $display("FAIL gap_idle_outputs: got %0d active cycles want 0", gap_bad); else pass_cnt++;
        for (int i = 0; i < 20; i++) send(8'(i), 1'b1);
        total_cnt++; if (cv0 !== 1'b1) $display("FAIL rst_pre_valid: got %b want 1", cv0); else pass_cnt++;
        #3;
        rst_n = 1'b0;
        #1;
        total_cnt++; if ({cv0, cs0, he0} !== 3'b000) $display("FAIL rst_async_flags: got %b want 000", {cv0, cs0, he0}); else pass_cnt++;
        total_cnt++; if (cd0 !== 8'h00) $display("FAIL rst_async_data: got %h want 00", cd0); else pass_cnt++;
        total_cnt++; if (st0 !== 2'b00) $display("FAIL rst_async_state: got %b want 00", st0); else pass_cnt++;
        rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_log();
        for (int i = 20; i < 120; i++) send(8'(i), 1'b1);
        total_cnt++; if (out0.size() != 0) $display("FAIL rst_spurious: got %0d bytes want 0", out0.size()); else pass_cnt++;
        total_cnt++; if (soc0.size() != 0) $display("FAIL rst_spurious_soc: got %0d want 0", soc0.size()); else pass_cnt++;
    endtask

    initial begin
        clear_log();
        test_reset();
        test_acquire();
        test_garbage();
        test_sync_errors();
        test_presync_error();
        test_idle();
        test_gaps_and_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
